// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer for the 12-bit RISC core.
// Generates the fetch address every cycle and drives the call/return stack
// (push on CALL, pop on RET, one-cycle bubble while popped data returns).
// Optional feature macro: STACK_ERR_TRAP_EN -- when defined, a stack
// overflow/underflow redirects the PC to TRAP_VEC instead of PC+1.

module pc_sequencer #(
   parameter int              PC_W      = 12,
   parameter int              DEPTH     = 8,
   parameter logic [PC_W-1:0] RESET_VEC = 12'h000,
   parameter logic [PC_W-1:0] TRAP_VEC  = 12'hFF0
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            Stall,
   input  logic            Call,
   input  logic            Ret,
   input  logic            Branch,
   input  logic [PC_W-1:0] TargetAddr,
   input  logic [PC_W-1:0] PopDataIn,
   input  logic            StackFull,
   output logic            PushEnbl,
   output logic            PopEnbl,
   output logic [PC_W-1:0] PushData,
   output logic [PC_W-1:0] PC,
   output logic            PCValid,
   output logic            StackErr
);

   localparam int DW = $clog2(DEPTH + 1);

`ifdef STACK_ERR_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef enum logic {
      FETCH    = 1'b0,
      RET_WAIT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [DW-1:0]   depth_q, depth_d;
   logic            err_q, err_d;
   logic            valid_q;
   logic            push_c, pop_c;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] err_pc;
   logic            depth_empty, depth_full;

   assign pc_inc      = pc_q + PC_W'(1);
   assign err_pc      = TRAP_EN ? TRAP_VEC : pc_inc;
   assign depth_empty = (depth_q == '0);
   assign depth_full  = (depth_q == DW'(DEPTH));

   // Next-state, next-PC and stack strobe decode (Stall > Ret > Call > Branch > seq)
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      depth_d = depth_q;
      err_d   = err_q;
      push_c  = 1'b0;
      pop_c   = 1'b0;
      case (state_q)
         FETCH: begin
            if (Stall) begin
               pc_d = pc_q;
            end else if (Ret) begin
               if (!depth_empty) begin
                  pop_c   = 1'b1;
                  depth_d = depth_q - DW'(1);
                  state_d = RET_WAIT;
               end else begin
                  err_d = 1'b1;
                  pc_d  = err_pc;
               end
            end else if (Call) begin
               if (!StackFull && !depth_full) begin
                  push_c  = 1'b1;
                  depth_d = depth_q + DW'(1);
                  pc_d    = TargetAddr;
               end else begin
                  err_d = 1'b1;
                  pc_d  = err_pc;
               end
            end else if (Branch) begin
               pc_d = TargetAddr;
            end else begin
               pc_d = pc_inc;
            end
         end
         RET_WAIT: begin
            pc_d    = PopDataIn;
            state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Sequencer state; PCValid is registered so it rises on the first edge after reset
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_VEC;
         depth_q <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         depth_q <= depth_d;
         err_q   <= err_d;
         valid_q <= (state_d == FETCH);
      end
   end

   // Strobes are combinational with the command but gated off while reset is held
   assign PushEnbl = push_c & Reset;
   assign PopEnbl  = pop_c & Reset;
   assign PushData = (push_c & Reset) ? pc_inc : '0;
   assign PC       = pc_q;
   assign PCValid  = valid_q;
   assign StackErr = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed-vector scoreboard bench for pc_sequencer.
// The driver applies one vector per cycle and queues its hand-computed
// expected outputs; the monitor pops and compares on the falling edge.

module tb_pc_sequencer;

   logic        Clk;
   logic        Reset;
   logic        Stall, Call, Ret, Branch, StackFull;
   logic [11:0] TargetAddr, PopDataIn;
   logic        PushEnbl, PopEnbl, PCValid, StackErr;
   logic [11:0] PushData, PC;

   typedef struct {
      int          id;
      logic [11:0] pc;
      logic        v;
      logic        push;
      logic        pop;
      logic [11:0] pd;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;

   pc_sequencer #(
      .PC_W      (12),
      .DEPTH     (8),
      .RESET_VEC (12'h000),
      .TRAP_VEC  (12'hFF0)
   ) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Stall      (Stall),
      .Call       (Call),
      .Ret        (Ret),
      .Branch     (Branch),
      .TargetAddr (TargetAddr),
      .PopDataIn  (PopDataIn),
      .StackFull  (StackFull),
      .PushEnbl   (PushEnbl),
      .PopEnbl    (PopEnbl),
      .PushData   (PushData),
      .PC         (PC),
      .PCValid    (PCValid),
      .StackErr   (StackErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // PC after an erroring CALL/RET
   function automatic logic [11:0] err_next(input logic [11:0] p);
`ifdef STACK_ERR_TRAP_EN
      err_next = 12'hFF0;
`else
      err_next = p + 12'h001;
`endif
   endfunction

   task automatic chk(input string nm, input int id, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s vec %0d: got %h expected %h", nm, id, act, exp);
      end
   endtask

   // Monitor: compare the oldest expectation against the DUT outputs
   always @(negedge Clk) begin
      if (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         chk("PC",       e.id, PC,               e.pc);
         chk("PCValid",  e.id, {11'd0, PCValid}, {11'd0, e.v});
         chk("PushEnbl", e.id, {11'd0, PushEnbl},{11'd0, e.push});
         chk("PopEnbl",  e.id, {11'd0, PopEnbl}, {11'd0, e.pop});
         chk("StackErr", e.id, {11'd0, StackErr},{11'd0, e.err});
         if (e.push) chk("PushData", e.id, PushData, e.pd);
      end
   end

   task automatic drive(input logic st, input logic ca, input logic re, input logic br,
                        input logic [11:0] ta, input logic [11:0] pdi, input logic full,
                        input logic [11:0] e_pc, input logic e_v, input logic e_push,
                        input logic e_pop, input logic [11:0] e_pd, input logic e_err);
      exp_t e;
      Stall = st; Call = ca; Ret = re; Branch = br;
      TargetAddr = ta; PopDataIn = pdi; StackFull = full;
      e.id = vec_id; e.pc = e_pc; e.v = e_v; e.push = e_push;
      e.pop = e_pop; e.pd = e_pd; e.err = e_err;
      sb.push_back(e);
      vec_id++;
   endtask

   task automatic step(input logic st, input logic ca, input logic re, input logic br,
                       input logic [11:0] ta, input logic [11:0] pdi, input logic full,
                       input logic [11:0] e_pc, input logic e_v, input logic e_push,
                       input logic e_pop, input logic [11:0] e_pd, input logic e_err);
      drive(st, ca, re, br, ta, pdi, full, e_pc, e_v, e_push, e_pop, e_pd, e_err);
      @(posedge Clk);
      #1;
   endtask

   task automatic idle(input logic [11:0] e_pc, input logic e_v, input logic e_err);
      step(0, 0, 0, 0, 12'h000, 12'h000, 0, e_pc, e_v, 0, 0, 12'h000, e_err);
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      idle(12'h000, 0, 0);
      Reset = 1'b1;
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [11:0] p, t, p1, p2;
      Reset = 1'b0;
      Stall = 0; Call = 0; Ret = 0; Branch = 0;
      TargetAddr = '0; PopDataIn = '0; StackFull = 0;
      @(posedge Clk);
      #1;

      // Reset held: state at reset values, strobes forced low even with Call asserted
      idle(12'h000, 0, 0);
      step(0, 1, 0, 0, 12'h200, 12'h000, 0, 12'h000, 0, 0, 0, 12'h000, 0);
      Reset = 1'b1;

      // Sequential fetch after release
      idle(12'h000, 0, 0);
      idle(12'h001, 1, 0);
      idle(12'h002, 1, 0);
      idle(12'h003, 1, 0);
      idle(12'h004, 1, 0);

      // Branch to 010, Call 200, Ret at 203
      step(0, 0, 0, 1, 12'h010, 12'h000, 0, 12'h005, 1, 0, 0, 12'h000, 0);
      step(0, 1, 0, 0, 12'h200, 12'h000, 0, 12'h010, 1, 1, 0, 12'h011, 0);
      idle(12'h200, 1, 0);
      idle(12'h201, 1, 0);
      idle(12'h202, 1, 0);
      step(0, 0, 1, 0, 12'h000, 12'h000, 0, 12'h203, 1, 0, 1, 12'h000, 0);
      // RET_WAIT ignores Stall/Call
      step(1, 1, 0, 0, 12'h777, 12'h011, 0, 12'h203, 0, 0, 0, 12'h000, 0);
      // Stall+Call+Ret together hold everything
      step(0, 1, 0, 0, 12'h300, 12'h000, 0, 12'h011, 1, 1, 0, 12'h012, 0);
      step(1, 1, 1, 0, 12'h400, 12'h000, 0, 12'h300, 1, 0, 0, 12'h000, 0);
      step(0, 1, 1, 0, 12'h400, 12'h000, 0, 12'h300, 1, 0, 1, 12'h000, 0);
      step(0, 0, 0, 0, 12'h000, 12'h012, 0, 12'h300, 0, 0, 0, 12'h000, 0);

      // Underflow: Ret with empty stack
      step(0, 0, 1, 0, 12'h000, 12'h000, 0, 12'h012, 1, 0, 0, 12'h000, 0);
      p = err_next(12'h012);
      step(0, 0, 0, 1, 12'hFFF, 12'h000, 0, p, 1, 0, 0, 12'h000, 1);
      // Wrap FFF -> 000
      idle(12'hFFF, 1, 1);
      idle(12'h000, 1, 1);

      // Reset asserted in the middle of RET_WAIT
      step(0, 1, 0, 0, 12'h050, 12'h000, 0, 12'h001, 1, 1, 0, 12'h002, 1);
      step(0, 0, 1, 0, 12'h000, 12'h000, 0, 12'h050, 1, 0, 1, 12'h000, 1);
      drive(0, 0, 0, 0, 12'h000, 12'h002, 0, 12'h050, 0, 0, 0, 12'h000, 1);
      @(negedge Clk);
      #1;
      Reset = 1'b0;
      @(posedge Clk);
      #1;
      idle(12'h000, 0, 0);
      Reset = 1'b1;
      idle(12'h000, 0, 0);
      // depth cleared: Ret underflows
      step(0, 0, 1, 0, 12'h000, 12'h000, 0, 12'h001, 1, 0, 0, 12'h000, 0);
      idle(err_next(12'h001), 1, 1);

      // Overflow: 8 nested Calls, then StackFull, then depth==DEPTH
      do_reset();
      idle(12'h000, 0, 0);
      for (int i = 0; i < 8; i++) begin
         p = (i == 0) ? 12'h001 : 12'(12'h100 + 12'h010 * (i - 1));
         t = 12'(12'h100 + 12'h010 * i);
         step(0, 1, 0, 0, t, 12'h000, 0, p, 1, 1, 0, 12'(p + 12'h001), 0);
      end
      step(0, 1, 0, 0, 12'h500, 12'h000, 1, 12'h170, 1, 0, 0, 12'h000, 0);
      p1 = err_next(12'h170);
      step(0, 1, 0, 0, 12'h600, 12'h000, 0, p1, 1, 0, 0, 12'h000, 1);
      p2 = err_next(p1);
      step(0, 0, 1, 0, 12'h000, 12'h000, 0, p2, 1, 0, 1, 12'h000, 1);
      step(0, 0, 0, 0, 12'h000, 12'h161, 0, p2, 0, 0, 0, 12'h000, 1);
      idle(12'h161, 1, 1);

      @(negedge Clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
